// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative WIDTH-bit multiply/divide unit for the execute stage.
// MULT/MULTU produce a 2*WIDTH-bit product as {hi,lo}; DIV/DIVU produce
// quotient in lo and remainder in hi. Each op takes WIDTH iteration cycles
// plus one sign-fixup cycle, so done appears WIDTH+1 cycles after accept.
// Build option: define ALU_MULDIV_DIV_EN to include the divider datapath;
// without it DIV/DIVU still take full latency and return lo=0, hi=0, dbz=1.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;   // negate product / quotient in FIX
  logic [WIDTH-1:0]   mag_b;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // {partial product | remainder, multiplier | quotient}
`ifdef ALU_MULDIV_DIV_EN
  logic               neg_rem;   // remainder follows the dividend sign
  logic               bz;        // divisor was zero
  logic [WIDTH-1:0]   a_raw;     // raw dividend, returned on divide-by-zero
`endif

  logic accept, last;
  assign accept = (state == IDLE) && start;
  assign last   = (count == CW'(WIDTH-1));

  // Operand magnitudes; unsigned ops never see a sign bit.
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sa    = ~op[0] & A[WIDTH-1];
  assign sb    = ~op[0] & B[WIDTH-1];
  assign abs_a = sa ? -A : A;
  assign abs_b = sb ? -B : B;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and busy decode.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx, acc_nx;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]     div_sh, div_df;
  logic [2*WIDTH-1:0] div_nx;
`endif
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_nx  = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
    // Bring the next dividend bit into the remainder and try a subtract.
    div_sh  = acc[2*WIDTH-1:WIDTH-1];
    div_df  = div_sh - {1'b0, mag_b};
    div_nx  = div_df[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    acc_nx  = is_div ? div_nx : mul_nx;
`else
    acc_nx  = mul_nx;
`endif
  end

  // Sign fixup and special cases for the result written in FIX.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic               fix_dbz;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH-1:0]   q_mag, r_mag;
`endif
  always_comb begin
    prod    = neg_res ? -acc : acc;
    fix_lo  = prod[WIDTH-1:0];
    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_dbz = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    q_mag   = acc[WIDTH-1:0];
    r_mag   = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      if (bz) begin
        fix_lo  = '1;
        fix_hi  = a_raw;
        fix_dbz = 1'b1;
      end else begin
        // Most-negative / -1 lands on 0x8000_0000 naturally via the magnitude path.
        fix_lo  = neg_res ? -q_mag : q_mag;
        fix_hi  = neg_rem ? -r_mag : r_mag;
      end
    end
`else
    if (is_div) begin
      fix_lo  = '0;
      fix_hi  = '0;
      fix_dbz = 1'b1;
    end
`endif
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      mag_b   <= '0;
      acc     <= '0;
`ifdef ALU_MULDIV_DIV_EN
      neg_rem <= 1'b0;
      bz      <= 1'b0;
      a_raw   <= '0;
`endif
      lo      <= '0;
      hi      <= '0;
      dbz     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        count   <= '0;
        is_div  <= op[1];
        neg_res <= sa ^ sb;
        mag_b   <= abs_b;
        acc     <= {{WIDTH{1'b0}}, abs_a};
`ifdef ALU_MULDIV_DIV_EN
        neg_rem <= sa;
        bz      <= (B == '0);
        a_raw   <= A;
`endif
      end else if (state == RUN) begin
        acc   <= acc_nx;
        count <= count + CW'(1);
      end else if (state == FIX) begin
        lo   <= fix_lo;
        hi   <= fix_hi;
        dbz  <= fix_dbz;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv. Stimulus pushes the
// expected result and completion time; a negedge monitor pops on done.
module tb_alu_muldiv;

  localparam int PER = 10;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, dbz;
  logic [31:0] lo, hi;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .lo(lo), .hi(hi), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #(PER/2) clk = ~clk;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    logic [63:0] t;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      p;
    logic [63:0] pu;
    e = '0;
    case (o)
      2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); {e.hi, e.lo} = p; end
      2'b01: begin pu = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = pu; end
      default: begin
`ifdef ALU_MULDIV_DIV_EN
        if (b == 32'd0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else if (o == 2'b11) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          int sa, sb;
          sa = a; sb = b;
          e.lo = sa / sb; e.hi = sa % sb;
        end
`else
        e.dbz = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  // Monitor: every done must match the head of the scoreboard at the exact time.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (sbq.size() > 0 && $time > sbq[0].t) begin
        total++; bad++;
        $display("FAIL done_missing want_t=%0t now=%0t", sbq[0].t, $time);
        void'(sbq.pop_front());
      end
      if (done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected lo=%h hi=%h at %0t", lo, hi, $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_time", $time, e.t);
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("dbz", dbz, e.dbz);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  // Issue one op at the current negedge; return at the negedge of its done cycle.
  // While hold>0 start stays high with junk operands, which must be ignored.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    e   = model(o, a, b);
    e.t = $time + 33*PER + PER/2;
    sbq.push_back(e);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_run", busy, 1);
      if (i < hold) begin
        start = 1'b1; op = 2'($urandom); A = $urandom; B = $urandom;
      end else start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lo", lo, 0);
    chk("rst_hi", hi, 0);
    chk("rst_dbz", dbz, 0);
    @(negedge clk); @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed cases; the last three run back-to-back from the done cycle.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    issue(2'b11, 32'd7, 32'd0, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 31);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Reset at iteration 10 aborts without a done.
    start = 1'b1; op = 2'b01; A = $urandom; B = $urandom;
    @(posedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_lo", lo, 0);
    chk("abort_hi", hi, 0);
    chk("abort_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd5, 0);

    // Randomized ops with occasional held start and idle gaps.
    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
